pc_fetch_unit: RTL and testbench

- Fetch stage of the multi-cycle core; sits directly upstream of instruction decode and the control FSM.
- Owns the `pc_cur` and `pc_old` registers and the instruction register.
- Issues word reads to instruction memory over a valid/ready request channel and a valid-only response channel.
- Applies PC redirects from the control FSM, for example the JALR jump target taken from the ALU result with the LSB cleared.

---
 rtl/pc_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Fetch stage of the multi-cycle core. Owns pc_cur, pc_old and the
// instruction register, issues one word read per fetch_start over a
// valid/ready request channel, and captures the valid-only response.
// PC redirects from the control FSM are applied immediately while the
// unit is idle, or held as a pending redirect while a fetch is in flight.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a redirect to an address with bit 1 set raises a sticky
//               fetch_misaligned flag, and further fetches are refused
//   undefined : fetch_misaligned is tied low
//
// Ports
//   clk              core clock, all state on posedge
//   reset            asynchronous, active-low reset
//   fetch_start      one-cycle pulse from the control FSM entering FETCH
//   pc_update        redirect request
//   pc_src           redirect source select (increment / ALU / target)
//   alu_result       ALU output, used for JALR targets (LSB cleared)
//   pc_target        precomputed branch/JAL target
//   mem_req_valid    read request valid
//   mem_req_ready    memory accepts the request
//   mem_addr         word-aligned fetch address
//   mem_rsp_valid    read data valid
//   mem_rsp_data     instruction word
//   instr            instruction register
//   instr_valid      one-cycle pulse when instr has been updated
//   pc_cur           PC of the next instruction to fetch
//   pc_old           PC of the instruction held in instr
//   fetch_busy       high while a request or response is outstanding
//   fetch_misaligned sticky misaligned-redirect flag
//
// state | meaning
// IDLE  | waiting for fetch_start
// REQ   | request presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid
// DONE  | instruction captured, instr_valid high for this cycle

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_update,
    input  logic [1:0]  pc_src,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_target,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_cur,
    output logic [31:0] pc_old,
    output logic        fetch_busy,
    output logic        fetch_misaligned
);

    // pc_src_t encodings; the unused encoding falls back to increment.
    localparam logic [1:0] PC_SRC__INCREMENT  = 2'd0;
    localparam logic [1:0] PC_SRC__ALU_RESULT = 2'd1;
    localparam logic [1:0] PC_SRC__TARGET     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_inc;
    logic [31:0] new_pc;
    logic        capture;
    logic        redirect_now;
    logic        redirect_hold;
    logic        fetch_allowed;

    logic        pend_valid;
    logic [31:0] pend_pc;

    // ------------------------------------------------------------------
    // Redirect target selection
    // ------------------------------------------------------------------
    always_comb begin
        pc_inc = pc_cur + 32'd4;
        new_pc = pc_inc;
        case (pc_src)
            PC_SRC__INCREMENT:  new_pc = pc_inc;
            PC_SRC__ALU_RESULT: new_pc = alu_result & ~32'h0000_0001;
            PC_SRC__TARGET:     new_pc = pc_target;
            default:            new_pc = pc_inc;
        endcase
    end

    // A response only counts while we are actually waiting for one; late
    // responses (e.g. after a mid-operation reset) are dropped here.
    assign capture       = (state_q == ST_WAIT) && mem_rsp_valid;
    assign redirect_now  = pc_update && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign redirect_hold = pc_update && ((state_q == ST_REQ)  || (state_q == ST_WAIT));

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misaligned_q <= 1'b0;
        end else if (pc_update && new_pc[1]) begin
            misaligned_q <= 1'b1;
        end
    end

    // Also refuse a fetch_start that coincides with the redirect that
    // trips the flag, so a misaligned address is never requested.
    assign fetch_allowed    = !misaligned_q && !(pc_update && new_pc[1]);
    assign fetch_misaligned = misaligned_q;
`else
    assign fetch_allowed    = 1'b1;
    assign fetch_misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_start && fetch_allowed) state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)                state_d = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid)                state_d = ST_DONE;
            ST_DONE:                                   state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_addr      = {pc_cur[31:2], 2'b00};
    assign fetch_busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign instr_valid   = (state_q == ST_DONE);

    // ------------------------------------------------------------------
    // PC, instruction register and pending redirect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_cur     <= RESET_PC;
            pc_old     <= 32'h0000_0000;
            instr      <= NOP_INSTR;
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0000_0000;
        end else if (capture) begin
            instr      <= mem_rsp_data;
            pc_old     <= pc_cur;
            pend_valid <= 1'b0;
            // A redirect arriving on the capture edge is the newest one and
            // wins over an older pending value.
            if (pc_update) begin
                pc_cur <= new_pc;
            end else if (pend_valid) begin
                pc_cur <= pend_pc;
            end else begin
                pc_cur <= pc_inc;
            end
        end else if (redirect_now) begin
            pc_cur <= new_pc;
        end else if (redirect_hold) begin
            pend_valid <= 1'b1;
            pend_pc    <= new_pc;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Inputs change 1 ns after each rising
// edge; outputs are sampled at the same point, before the inputs change.

module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic        pc_update;
    logic [1:0]  pc_src;
    logic [31:0] alu_result;
    logic [31:0] pc_target;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_cur;
    logic [31:0] pc_old;
    logic        fetch_busy;
    logic        fetch_misaligned;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_start      (fetch_start),
        .pc_update        (pc_update),
        .pc_src           (pc_src),
        .alu_result       (alu_result),
        .pc_target        (pc_target),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_addr         (mem_addr),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .pc_cur           (pc_cur),
        .pc_old           (pc_old),
        .fetch_busy       (fetch_busy),
        .fetch_misaligned (fetch_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        fetch_start   = 1'b0;
        pc_update     = 1'b0;
        pc_src        = 2'd0;
        alu_result    = 32'h0;
        pc_target     = 32'h0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;

        // ---------------- reset state
        tick();
        tick();
        check("rst_pc_cur",  pc_cur, 32'h0);
        check("rst_pc_old",  pc_old, 32'h0);
        check("rst_instr",   instr, 32'h0000_0013);
        check("rst_ivalid",  {31'b0, instr_valid}, 32'h0);
        check("rst_reqv",    {31'b0, mem_req_valid}, 32'h0);
        check("rst_busy",    {31'b0, fetch_busy}, 32'h0);
        check("rst_misal",   {31'b0, fetch_misaligned}, 32'h0);
        reset = 1'b1;
        tick();

        // ---------------- minimum latency fetch, M[0]=005100E7
        fetch_start   = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0051_00E7;
        tick();                                   // -> REQ
        check("f1_reqv",   {31'b0, mem_req_valid}, 32'h1);
        check("f1_addr",   mem_addr, 32'h0);
        check("f1_iv_c1",  {31'b0, instr_valid}, 32'h0);
        fetch_start = 1'b0;
        tick();                                   // -> WAIT
        check("f1_iv_c2",  {31'b0, instr_valid}, 32'h0);
        check("f1_busy",   {31'b0, fetch_busy}, 32'h1);
        tick();                                   // -> DONE
        check("f1_iv_c3",  {31'b0, instr_valid}, 32'h1);
        check("f1_instr",  instr, 32'h0051_00E7);
        check("f1_pc_old", pc_old, 32'h0);
        check("f1_pc_cur", pc_cur, 32'h4);
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        tick();                                   // -> IDLE
        check("f1_iv_off", {31'b0, instr_valid}, 32'h0);

        // ---------------- stalled request and delayed response
        fetch_start = 1'b1;
        tick();                                   // -> REQ
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("st_reqv", {31'b0, mem_req_valid}, 32'h1);
            check("st_addr", mem_addr, 32'h4);
            check("st_busy", {31'b0, fetch_busy}, 32'h1);
            tick();
        end
        check("st_reqv_4", {31'b0, mem_req_valid}, 32'h1);
        mem_req_ready = 1'b1;
        tick();                                   // -> WAIT
        mem_req_ready = 1'b0;
        check("st_wait_req", {31'b0, mem_req_valid}, 32'h0);
        tick();
        check("st_wait_iv1", {31'b0, instr_valid}, 32'h0);
        check("st_wait_ins", instr, 32'h0051_00E7);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0093;
        tick();                                   // -> DONE
        mem_rsp_valid = 1'b0;
        check("st_iv",     {31'b0, instr_valid}, 32'h1);
        check("st_instr",  instr, 32'h0000_0093);
        check("st_pc_cur", pc_cur, 32'h8);
        tick();
        check("st_iv_off", {31'b0, instr_valid}, 32'h0);
        tick();
        check("st_iv_off2", {31'b0, instr_valid}, 32'h0);

        // ---------------- redirect to target while in WAIT
        fetch_start   = 1'b1;
        mem_req_ready = 1'b1;
        tick();                                   // -> REQ
        fetch_start = 1'b0;
        tick();                                   // -> WAIT
        mem_req_ready = 1'b0;
        pc_update     = 1'b1;
        pc_src        = 2'd2;
        pc_target     = 32'h40;
        tick();                                   // held pending
        pc_update = 1'b0;
        check("rw_pc_hold", pc_cur, 32'h8);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0113;
        tick();                                   // -> DONE
        mem_rsp_valid = 1'b0;
        check("rw_pc_old", pc_old, 32'h8);
        check("rw_pc_cur", pc_cur, 32'h40);
        check("rw_instr",  instr, 32'h0000_0113);
        tick();

        // ---------------- ALU redirects in IDLE, LSB cleared
        pc_update  = 1'b1;
        pc_src     = 2'd1;
        alu_result = 32'd105;
        tick();
        check("alu_105", pc_cur, 32'd104);
        alu_result = 32'd193;
        tick();
        check("alu_193", pc_cur, 32'd192);
        pc_update     = 1'b0;
        fetch_start   = 1'b1;
        mem_req_ready = 1'b1;
        tick();                                   // -> REQ
        fetch_start = 1'b0;
        check("alu_addr", mem_addr, 32'd192);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0213;
        tick();                                   // -> WAIT
        tick();                                   // -> DONE
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        check("alu_pc_old", pc_old, 32'd192);
        check("alu_pc_cur", pc_cur, 32'd196);
        tick();

        // ---------------- increment source and undefined encoding
        pc_update = 1'b1;
        pc_src    = 2'd0;
        tick();
        check("src_inc", pc_cur, 32'd200);
        pc_src = 2'd3;
        tick();
        check("src_undef", pc_cur, 32'd204);
        pc_update = 1'b0;

        // ---------------- simultaneous start + redirect, PC wrap
        fetch_start   = 1'b1;
        pc_update     = 1'b1;
        pc_src        = 2'd2;
        pc_target     = 32'hFFFF_FFFC;
        mem_req_ready = 1'b1;
        tick();                                   // -> REQ
        fetch_start = 1'b0;
        pc_update   = 1'b0;
        check("sim_addr", mem_addr, 32'hFFFF_FFFC);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0313;
        tick();                                   // -> WAIT
        fetch_start = 1'b1;                       // ignored outside IDLE
        tick();                                   // -> DONE
        fetch_start   = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        check("wrap_pc_old", pc_old, 32'hFFFF_FFFC);
        check("wrap_pc_cur", pc_cur, 32'h0);
        tick();
        check("ign_start_busy", {31'b0, fetch_busy}, 32'h0);

        // ---------------- reset during WAIT, late response dropped
        pc_update = 1'b1;
        pc_src    = 2'd2;
        pc_target = 32'h80;
        tick();
        pc_update     = 1'b0;
        fetch_start   = 1'b1;
        mem_req_ready = 1'b1;
        tick();                                   // -> REQ
        fetch_start = 1'b0;
        tick();                                   // -> WAIT
        mem_req_ready = 1'b0;
        check("rw_busy", {31'b0, fetch_busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("ar_pc_cur", pc_cur, 32'h0);
        check("ar_instr",  instr, 32'h0000_0013);
        check("ar_busy",   {31'b0, fetch_busy}, 32'h0);
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        check("late_iv1", {31'b0, instr_valid}, 32'h0);
        tick();
        check("late_iv2",   {31'b0, instr_valid}, 32'h0);
        check("late_instr", instr, 32'h0000_0013);
        check("late_pc",    pc_cur, 32'h0);
        mem_rsp_valid = 1'b0;
        tick();

        // ---------------- misaligned redirect
        pc_update = 1'b1;
        pc_src    = 2'd2;
        pc_target = 32'h6;
        tick();
        pc_update = 1'b0;
        check("mis_pc_cur", pc_cur, 32'h6);
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_flag", {31'b0, fetch_misaligned}, 32'h1);
`else
        check("mis_flag", {31'b0, fetch_misaligned}, 32'h0);
`endif
        fetch_start   = 1'b1;
        mem_req_ready = 1'b1;
        tick();
        fetch_start = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_reqv", {31'b0, mem_req_valid}, 32'h0);
        check("mis_busy", {31'b0, fetch_busy}, 32'h0);
        tick();
        check("mis_reqv2", {31'b0, mem_req_valid}, 32'h0);
`else
        check("mis_reqv", {31'b0, mem_req_valid}, 32'h1);
        check("mis_addr", mem_addr, 32'h4);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0413;
        tick();                                   // -> WAIT
        tick();                                   // -> DONE
        mem_rsp_valid = 1'b0;
        check("mis_instr", instr, 32'h0000_0413);
        check("mis_pc_nx", pc_cur, 32'hA);
        check("mis_flag2", {31'b0, fetch_misaligned}, 32'h0);
`endif
        mem_req_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
